// File: rtl/fifo_fwft_stage_pkg.sv
// Shared definitions for the FWFT read-side stage: the local occupancy encoding
// that level_o reports and that the stage's two-process FSM steps through.
package fifo_fwft_stage_pkg;

   typedef enum logic [1:0] {
      LVL_EMPTY = 2'd0,
      LVL_ONE   = 2'd1,
      LVL_TWO   = 2'd2
   } level_e;

   localparam int unsigned MAX_LEVEL = 2;

endpackage

// File: rtl/fifo_fwft_stage.sv
// First-word-fall-through adapter behind a FIFO with a one-cycle registered read:
// issues read strobes, absorbs the read latency in a head/skid pair, presents valid/ready.
module fifo_fwft_stage
   import fifo_fwft_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] fifo_data_i,
   input  logic                  fifo_empty_i,
   output logic                  fifo_rd_en_o,
   input  logic                  flush_i,
   output logic [DATA_WIDTH-1:0] dout_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [1:0]            level_o
);

   if (DATA_WIDTH < 1) begin : g_bad_width
      $error("fifo_fwft_stage: DATA_WIDTH must be greater than 0");
   end

   level_e                level_q, level_d;
   logic                  inflight_q;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic                  pop;
   logic                  capture;
   logic [2:0]            committed;

   assign valid_o = (level_q != LVL_EMPTY);
   assign dout_o  = head_q;
   assign level_o = level_q;
   assign pop     = valid_o & ready_i;

   // A word returning during a flush is dropped rather than captured.
   assign capture = inflight_q & ~flush_i;

   // Words held plus the one in flight, after this cycle's pop; ready_i reaches
   // the read strobe combinationally so a full stage can refill while it drains.
   assign committed    = {1'b0, level_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign fifo_rd_en_o = ~rst & ~flush_i & ~fifo_empty_i & (committed < 3'(MAX_LEVEL));

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      level_d = level_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush_i) begin
         level_d = LVL_EMPTY;
      end else begin
         case (level_q)
            LVL_EMPTY: begin
               if (capture) begin
                  head_d  = fifo_data_i;
                  level_d = LVL_ONE;
               end
            end
            LVL_ONE: begin
               if (capture && pop) begin
                  head_d = fifo_data_i;
               end else if (capture) begin
                  skid_d  = fifo_data_i;
                  level_d = LVL_TWO;
               end else if (pop) begin
                  level_d = LVL_EMPTY;
               end
            end
            LVL_TWO: begin
               if (pop) begin
                  head_d = skid_q;
                  if (capture) begin
                     skid_d = fifo_data_i;
                  end else begin
                     level_d = LVL_ONE;
                  end
               end
            end
            default: level_d = LVL_EMPTY;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q    <= LVL_EMPTY;
         inflight_q <= 1'b0;
         head_q     <= '0;
      end else begin
         level_q    <= level_d;
         inflight_q <= fifo_rd_en_o;
         head_q     <= head_d;
      end
   end

   // NOTE: the skid data register is deliberately not reset; it is only read when level is TWO.
   always_ff @(posedge clk) begin
      skid_q <= skid_d;
   end

endmodule

// File: tb/tb_fifo_fwft_stage.sv
// Directed and random bench for fifo_fwft_stage behind a 4-deep FIFO model with a
// registered read port; vectors carry hand-computed per-cycle expectations.
module tb_fifo_fwft_stage;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] fifo_data;
   logic       fifo_empty;
   logic       fifo_rd_en;
   logic       flush;
   logic [7:0] dout;
   logic       valid;
   logic       ready;
   logic [1:0] level;

   logic       wr_en;
   logic [7:0] wr_data;

   int checks   = 0;
   int failures = 0;
   int viol     = 0;

   always #5 clk = ~clk;

   fifo_fwft_stage #(.DATA_WIDTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_data_i  (fifo_data),
      .fifo_empty_i (fifo_empty),
      .fifo_rd_en_o (fifo_rd_en),
      .flush_i      (flush),
      .dout_o       (dout),
      .valid_o      (valid),
      .ready_i      (ready),
      .level_o      (level)
   );

   // FIFO model: depth 4, rd_data registered one cycle after the read strobe.
   logic [7:0] fmem [4];
   logic [1:0] wp, rp;
   logic [2:0] fcnt;
   logic       ffull;
   logic       fwr;

   assign fifo_empty = (fcnt == 3'd0);
   assign ffull      = (fcnt == 3'd4);
   assign fwr        = wr_en & ~ffull;

   always @(posedge clk) begin
      if (rst) begin
         wp   <= '0;
         rp   <= '0;
         fcnt <= '0;
      end else begin
         if (fwr) begin
            fmem[wp] <= wr_data;
            wp       <= wp + 2'd1;
         end
         if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= fmem[rp];
            rp        <= rp + 2'd1;
         end
         fcnt <= fcnt + 3'(fwr) - 3'(fifo_rd_en && !fifo_empty);
      end
   end

   always @(negedge clk) begin
      if (!rst && ((fifo_rd_en && fifo_empty) || level > 2'd2)) viol++;
   end

   typedef struct {
      logic       wr;
      logic [7:0] wd;
      logic       rdy;
      logic       fl;
      logic       rd;
      logic       v;
      logic [7:0] d;
      logic [1:0] l;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic wr, input logic [7:0] wd, input logic rdy, input logic fl,
                      input logic rd, input logic v, input logic [7:0] d, input logic [1:0] l);
      vec_t t;
      t.wr = wr; t.wd = wd; t.rdy = rdy; t.fl = fl;
      t.rd = rd; t.v = v; t.d = d; t.l = l;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic wr, input logic [7:0] wd, input logic rdy,
                         input logic fl, input logic rs);
      wr_en = wr; wr_data = wd; ready = rdy; flush = fl; rst = rs;
   endtask

   logic [7:0] sb[$];
   logic [7:0] exp_b;
   int         drain;

   initial begin
      set_in(0, 8'h00, 0, 0, 1);
      adv();
      @(negedge clk);
      check("reset valid", 32'(valid), 32'd0);
      check("reset dout", 32'(dout), 32'h00);
      check("reset level", 32'(level), 32'd0);
      check("reset rd_en", 32'(fifo_rd_en), 32'd0);
      adv();
      rst = 1'b0;

      // 1: single word
      add(1, 8'hA5, 1, 0,  0, 0, 8'h00, 0);
      add(0, 8'h00, 1, 0,  1, 0, 8'h00, 0);
      add(0, 8'h00, 1, 0,  0, 0, 8'h00, 0);
      add(0, 8'h00, 1, 0,  0, 1, 8'hA5, 1);
      add(0, 8'h00, 1, 0,  0, 0, 8'hA5, 0);
      // 2: streaming
      add(1, 8'h01, 1, 0,  0, 0, 8'hA5, 0);
      add(1, 8'h02, 1, 0,  1, 0, 8'hA5, 0);
      add(1, 8'h03, 1, 0,  1, 0, 8'hA5, 0);
      add(1, 8'h04, 1, 0,  1, 1, 8'h01, 1);
      add(0, 8'h00, 1, 0,  1, 1, 8'h02, 1);
      add(0, 8'h00, 1, 0,  0, 1, 8'h03, 1);
      add(0, 8'h00, 1, 0,  0, 1, 8'h04, 1);
      add(0, 8'h00, 1, 0,  0, 0, 8'h04, 0);
      // 3: backpressure
      add(1, 8'h10, 0, 0,  0, 0, 8'h04, 0);
      add(1, 8'h11, 0, 0,  1, 0, 8'h04, 0);
      add(1, 8'h12, 0, 0,  1, 0, 8'h04, 0);
      add(1, 8'h13, 0, 0,  0, 1, 8'h10, 1);
      add(0, 8'h00, 0, 0,  0, 1, 8'h10, 2);
      add(0, 8'h00, 0, 0,  0, 1, 8'h10, 2);
      add(0, 8'h00, 0, 0,  0, 1, 8'h10, 2);
      add(0, 8'h00, 0, 0,  0, 1, 8'h10, 2);
      add(0, 8'h00, 1, 0,  1, 1, 8'h10, 2);
      add(0, 8'h00, 1, 0,  1, 1, 8'h11, 1);
      add(0, 8'h00, 1, 0,  0, 1, 8'h12, 1);
      add(0, 8'h00, 1, 0,  0, 1, 8'h13, 1);
      add(0, 8'h00, 1, 0,  0, 0, 8'h13, 0);
      // 4: flush with a word in flight (word 22 must never appear)
      add(1, 8'h20, 0, 0,  0, 0, 8'h13, 0);
      add(1, 8'h21, 0, 0,  1, 0, 8'h13, 0);
      add(1, 8'h22, 0, 0,  1, 0, 8'h13, 0);
      add(1, 8'h23, 0, 0,  0, 1, 8'h20, 1);
      add(1, 8'h24, 0, 0,  0, 1, 8'h20, 2);
      add(0, 8'h00, 1, 0,  1, 1, 8'h20, 2);
      add(0, 8'h00, 0, 1,  0, 1, 8'h21, 1);
      add(0, 8'h00, 1, 0,  1, 0, 8'h21, 0);
      add(0, 8'h00, 1, 0,  1, 0, 8'h21, 0);
      add(0, 8'h00, 1, 0,  0, 1, 8'h23, 1);
      add(0, 8'h00, 1, 0,  0, 1, 8'h24, 1);
      add(0, 8'h00, 1, 0,  0, 0, 8'h24, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         set_in(vecs[i].wr, vecs[i].wd, vecs[i].rdy, vecs[i].fl, 0);
         @(negedge clk);
         check($sformatf("vec%0d rd_en", i), 32'(fifo_rd_en), 32'(vecs[i].rd));
         check($sformatf("vec%0d valid", i), 32'(valid), 32'(vecs[i].v));
         check($sformatf("vec%0d dout", i), 32'(dout), 32'(vecs[i].d));
         check($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].l));
         adv();
      end

      // 5: reset mid-stream
      set_in(1, 8'h31, 1, 0, 0); adv();
      set_in(1, 8'h32, 1, 0, 0); adv();
      set_in(1, 8'h33, 1, 0, 0); adv();
      set_in(0, 8'h00, 1, 0, 1);
      @(negedge clk);
      check("rst gate rd_en", 32'(fifo_rd_en), 32'd0);
      check("pre-rst valid", 32'(valid), 32'd1);
      check("pre-rst dout", 32'(dout), 32'h31);
      adv();
      set_in(1, 8'h5A, 1, 0, 0);
      @(negedge clk);
      check("post-rst valid", 32'(valid), 32'd0);
      check("post-rst dout", 32'(dout), 32'h00);
      check("post-rst level", 32'(level), 32'd0);
      check("post-rst rd_en", 32'(fifo_rd_en), 32'd0);
      adv();
      set_in(0, 8'h00, 1, 0, 0);
      @(negedge clk);
      check("5A rd_en", 32'(fifo_rd_en), 32'd1);
      check("5A valid early", 32'(valid), 32'd0);
      adv();
      @(negedge clk);
      check("5A valid early2", 32'(valid), 32'd0);
      adv();
      @(negedge clk);
      check("5A valid", 32'(valid), 32'd1);
      check("5A dout", 32'(dout), 32'h5A);
      check("5A level", 32'(level), 32'd1);
      adv();
      @(negedge clk);
      check("5A alone", 32'(valid), 32'd0);
      adv();

      // 6: random traffic against a scoreboard
      for (int c = 0; c < 10000; c++) begin
         set_in(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 0, 0);
         if (ffull) wr_en = 1'b0;
         if (wr_en) sb.push_back(wr_data);
         @(negedge clk);
         if (valid && ready) begin
            if (sb.size() == 0) begin
               check("rand pop with empty scoreboard", 32'(dout), 32'hFFFF_FFFF);
            end else begin
               exp_b = sb.pop_front();
               check("rand dout", 32'(dout), 32'(exp_b));
            end
         end
         adv();
      end

      drain = 0;
      set_in(0, 8'h00, 1, 0, 0);
      while ((sb.size() != 0) && (drain < 50)) begin
         @(negedge clk);
         if (valid) begin
            exp_b = sb.pop_front();
            check("drain dout", 32'(dout), 32'(exp_b));
         end
         adv();
         drain++;
      end
      check("drain leftover words", 32'(sb.size()), 32'd0);
      @(negedge clk);
      check("drain final valid", 32'(valid), 32'd0);
      check("rd_en while empty or level>2", 32'(viol), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
